// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, [even parity if UART_TX_PARITY_EN], stop bit.
// Latency: accept edge -> start bit on tx_out right after that edge; tx_done pulses 10*D (11*D) clocks later.
// Backpressure: tx_start is ignored while tx_busy=1; a request held through tx_done is taken back-to-back.
module uart_tx #(
  parameter int              DIV_W        = 20,
  parameter logic [DIV_W-1:0] DEFAULT_BAUD = 20'd20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic [DIV_W-1:0] baud,
  input  logic             tx_en,
  input  logic             tx_start,
  input  logic [7:0]       tx_data,
  output logic             tx_out,
  output logic             tx_busy,
  output logic             tx_done
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       idx_q, idx_d;
  logic             tx_out_q, tx_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  logic [DIV_W-1:0] div_sel;
  logic [DIV_W-1:0] div_eff;
  logic             bit_end;

  // Divisors below 2 would leave no room for the counter to roll, so they clamp to 2.
  assign div_sel = sel ? baud : DEFAULT_BAUD;
  assign div_eff = (div_sel < DIV_W'(2)) ? DIV_W'(2) : div_sel;
  assign bit_end = (cnt_q == div_q - DIV_W'(1));

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    tx_out_d = tx_out_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    cnt_d    = (state_q == IDLE || bit_end) ? '0 : cnt_q + DIV_W'(1);

    case (state_q)
      IDLE: begin
        tx_out_d = 1'b1;
        if (tx_en && tx_start) begin
          shift_d  = tx_data;
          div_d    = div_eff;
          idx_d    = 3'd0;
          busy_d   = 1'b1;
          tx_out_d = 1'b0;
          state_d  = START;
`ifdef UART_TX_PARITY_EN
          par_d    = ^tx_data;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          tx_out_d = shift_q[0];
          state_d  = DATA;
        end
      end
      DATA: begin
        // shift_q[0] is the bit on the line; the next one sits in shift_q[1].
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_out_d = par_q;
            state_d  = PARITY;
`else
            tx_out_d = 1'b1;
            state_d  = STOP;
`endif
          end else begin
            idx_d    = idx_q + 3'd1;
            tx_out_d = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          tx_out_d = 1'b1;
          state_d  = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          tx_out_d = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        tx_out_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
      tx_out_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      tx_out_q <= tx_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign tx_out  = tx_out_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus pushes expected frames, a monitor decodes tx_out cycle by cycle.
module tb_uart_tx;

  localparam int DIV_W = 20;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sel = 1'b1;
  logic [DIV_W-1:0] baud = 20'd20;
  logic             tx_en = 1'b0;
  logic             tx_start = 1'b0;
  logic [7:0]       tx_data = 8'h00;
  logic             tx_out, tx_busy, tx_done;

  uart_tx dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .baud     (baud),
    .tx_en    (tx_en),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_out   (tx_out),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dat;
    int         div;
    bit         par;
    int         acc;
    bit         b2b;
    bit         abort;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_done_cyc = -100;
  bit   mon_active = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic logic exp_bit(input exp_t e, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return e.dat[b-1];
    if (b == NB - 1) return 1'b1;
    return e.par;
  endfunction

  // Called at the first sample of a start bit; checks every clock of the frame and the done pulse.
  task automatic run_frame(input exp_t e);
    bit aborted;
    aborted = 1'b0;
    if (e.acc >= 0) chk("start_latency", cyc, e.acc);
    if (e.b2b) chk("b2b_done_to_start", cyc - last_done_cyc, 1);
    for (int b = 0; b < NB; b++) begin
      logic want, g_out, g_busy, g_done;
      int   bad_c;
      want = exp_bit(e, b);
      bad_c = -1;
      g_out = 1'b0; g_busy = 1'b0; g_done = 1'b0;
      for (int c = 0; c < e.div; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (!rst) begin
          aborted = 1'b1;
          break;
        end
        if (bad_c < 0 && (tx_out !== want || tx_busy !== 1'b1 || tx_done !== 1'b0)) begin
          bad_c = c; g_out = tx_out; g_busy = tx_busy; g_done = tx_done;
        end
      end
      if (aborted) break;
      n_vec++;
      if (bad_c >= 0) begin
        n_bad++;
        $display("FAIL frame %02h bit %0d clock %0d/%0d: tx_out=%b busy=%b done=%b, expected tx_out=%b busy=1 done=0",
                 e.dat, b, bad_c, e.div, g_out, g_busy, g_done, want);
      end
    end
    if (aborted) begin
      n_vec++;
      if (!e.abort) begin
        n_bad++;
        $display("FAIL frame %02h cut short by reset, expected completion", e.dat);
      end
    end else begin
      @(negedge clk);
      chk("done_busy_out_at_end", {29'd0, tx_done, tx_busy, tx_out}, 32'b101);
      last_done_cyc = cyc;
      n_vec++;
      if (e.abort) begin
        n_bad++;
        $display("FAIL frame %02h completed, expected abort by reset", e.dat);
      end
    end
  endtask

  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (cyc == last_done_cyc + 1) chk("done_one_cycle", tx_done, 1'b0);
        else if (tx_done) chk("spurious_done", tx_done, 1'b0);
        if (prev && !tx_out) begin
          mon_active = 1'b1;
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            run_frame(e);
          end
          mon_active = 1'b0;
        end
      end
      prev = tx_out;
    end
  end

  task automatic send(input logic [7:0] d, input logic s, input logic [DIV_W-1:0] b,
                      input int dexp, input bit pexp, input bit ab);
    exp_t e;
    @(negedge clk);
    sel = s; baud = b; tx_data = d; tx_start = 1'b1;
    e.dat = d; e.div = dexp; e.par = pexp; e.acc = cyc + 1; e.b2b = 1'b0; e.abort = ab;
    exp_q.push_back(e);
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((mon_active || exp_q.size() != 0 || tx_busy) && n < 3000);
    chk(name, n < 3000, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_t e;
    int   n;
    bit   seen;
    #1 rst = 1'b0;
    tx_start = 1'b1; tx_en = 1'b1; tx_data = 8'h55;
    repeat (2) @(negedge clk);
    chk("reset_tx_out", tx_out, 1'b1);
    chk("reset_busy", tx_busy, 1'b0);
    chk("reset_done", tx_done, 1'b0);
    tx_en = 1'b0;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("en_low_tx_out", tx_out, 1'b1);
    chk("en_low_busy", tx_busy, 1'b0);
    tx_start = 1'b0;
    tx_en = 1'b1;

    // basic frame, default divisor (baud port ignored), clamp of 0 and 1
    send(8'h55, 1'b1, 20'd20, 20, 1'b0, 1'b0); wait_idle("idle_55");
    send(8'hA3, 1'b0, 20'd7,  20, 1'b0, 1'b0); wait_idle("idle_a3");
    send(8'h3D, 1'b1, 20'd0,  2,  1'b1, 1'b0); wait_idle("idle_3d");
    send(8'h83, 1'b1, 20'd1,  2,  1'b1, 1'b0); wait_idle("idle_83");

    // back-to-back with tx_start held; tx_data change after accept must not leak in
    @(negedge clk);
    sel = 1'b1; baud = 20'd20; tx_data = 8'h0F; tx_start = 1'b1;
    e.dat = 8'h0F; e.div = 20; e.par = 1'b0; e.acc = cyc + 1; e.b2b = 1'b0; e.abort = 1'b0;
    exp_q.push_back(e);
    e.dat = 8'hF0; e.acc = -1; e.b2b = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    tx_data = 8'hF0;
    n = 0;
    while (!tx_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_done", tx_done, 1'b1);
    @(negedge clk);
    tx_start = 1'b0; tx_data = 8'hAA;
    wait_idle("idle_b2b");

    // mid-frame tx_start pulse is dropped; mid-frame baud change is ignored
    send(8'h96, 1'b1, 20'd20, 20, 1'b0, 1'b0);
    repeat (50) @(negedge clk);
    tx_start = 1'b1; tx_data = 8'hFF;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (30) @(negedge clk);
    baud = 20'd5;
    wait_idle("idle_96");

    // tx_en dropped during bit 3 with tx_start held: frame finishes, nothing follows
    @(negedge clk);
    sel = 1'b1; baud = 20'd4; tx_data = 8'hC5; tx_start = 1'b1; tx_en = 1'b1;
    e.dat = 8'hC5; e.div = 4; e.par = 1'b0; e.acc = cyc + 1; e.b2b = 1'b0; e.abort = 1'b0;
    exp_q.push_back(e);
    repeat (17) @(negedge clk);
    tx_en = 1'b0;
    wait_idle("idle_c5");
    repeat (60) @(negedge clk);
    chk("en_gate_busy", tx_busy, 1'b0);
    tx_start = 1'b0;
    tx_en = 1'b1;

    // async reset during bit 5
    send(8'hE1, 1'b1, 20'd4, 4, 1'b0, 1'b1);
    repeat (25) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midreset_tx_out", tx_out, 1'b1);
    chk("midreset_busy", tx_busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (tx_done) seen = 1'b1;
    end
    chk("no_done_after_reset", seen, 1'b0);
    chk("idle_after_reset", tx_out, 1'b1);

`ifdef UART_TX_PARITY_EN
    send(8'h07, 1'b1, 20'd20, 20, 1'b1, 1'b0); wait_idle("idle_07");
`endif

    repeat (20) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter and counterpart of uart_rx in the midterm UART block. It serialises one 8-bit byte per request into a standard frame: start bit 0, eight data bits LSB first, stop bit 1. Bit period is a programmable clock-cycle divisor. Used with uart_rx for loopback and SoC serial output.

Parameters:
DEFAULT_BAUD, 20'd20, clocks per bit used when sel=0
DIV_W, 20, width of the baud divisor and bit-period counter

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset
sel  input  1  divisor select: 1 = use baud port, 0 = use DEFAULT_BAUD
baud  input  DIV_W  clocks per bit when sel=1
tx_en  input  1  transmitter enable; gates acceptance of new frames
tx_start  input  1  request to send tx_data; single-cycle or level
tx_data  input  8  byte to send, sampled on the accepting edge
tx_out  output  1  serial line, idle high
tx_busy  output  1  high while a frame is in progress
tx_done  output  1  one-cycle pulse when the stop bit completes

Behaviour:
- Reset (rst=0, async): tx_out=1, tx_busy=0, tx_done=0, state=IDLE, counters=0, shift register=0. Takes effect immediately, including mid-frame; the line returns high.
- Effective divisor D: latched at frame accept as (sel ? baud : DEFAULT_BAUD). Values 0 or 1 are clamped to 2. Changes to baud or sel mid-frame have no effect.
- States: IDLE -> START -> DATA -> STOP -> IDLE (PARITY between DATA and STOP only when the optional feature is enabled).
- IDLE: tx_out=1. Accept when tx_en=1 and tx_start=1 on a rising edge. On accept: latch tx_data and D, set tx_busy=1 on the same edge, go to START.
- Latency: accept at edge N -> tx_out=0 from edge N+1.
- Bit timing: each bit is held for exactly D clocks. The bit counter runs 0..D-1; at D-1 the next bit is driven.
- DATA: bits 0..7 are sent LSB first by shifting right. A 3-bit index counts bits; after bit 7 go to STOP.
- STOP: tx_out=1 for D clocks. On the last cycle of STOP go to IDLE, drop tx_busy, and pulse tx_done for one cycle, all on the same edge.
- Frame length: 10*D clocks accept-to-done (11*D with parity).
- tx_start while busy: ignored, not queued.
- Back-to-back: tx_start=1 and tx_en=1 in the cycle tx_done is high are accepted. The next start bit begins the following edge, so the stop bit is never shortened.
- tx_en deasserted mid-frame: the current frame completes normally; no new frame is accepted until tx_en=1.
- tx_data changes after accept: no effect on the frame in flight.
- tx_out is driven directly from a flop (glitch-free). No combinational path from any input to tx_out.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: add state PARITY after DATA. tx_out carries even parity (XOR of the 8 latched bits) for D clocks, then STOP. Frame is 11*D clocks.
- Undefined: no PARITY state and no parity logic; frame is 10*D clocks.
- uart_rx must be built with the matching setting.

Test Plan:
- Reset: hold rst=0 for 2 cycles with tx_start=1 -> tx_out=1, tx_busy=0, tx_done=0. Release; tx_out stays 1 while tx_en=0.
- Basic frame: sel=1, baud=20, tx_en=1, 1-cycle tx_start with tx_data=8'h55.
  - tx_out sequence 0,1,0,1,0,1,0,1,0,1, each exactly 20 clocks.
  - tx_done pulses 200 clocks after accept; tx_busy low from that edge.
  - Loopback into uart_rx with the same baud -> rx_data=8'h55.
- Default divisor and clamp:
  - sel=0 (DEFAULT_BAUD=20), tx_data=8'hA3 -> bits 1,1,0,0,0,1,0,1 LSB first, 20 clocks each.
  - sel=1, baud=0 -> 2 clocks per bit, frame 20 clocks.
- Back-to-back and ignore:
  - Hold tx_start=1 with tx_data=8'h0F then 8'hF0 -> two frames with exactly 20 clocks of stop between them.
  - A pulse of tx_start mid-frame sends no extra frame.
  - Changing baud mid-frame leaves bit width unchanged.
- tx_en and reset mid-frame:
  - Drop tx_en at bit 3 -> frame completes, then no new accept.
  - Assert rst=0 at bit 5 -> tx_out=1 and tx_busy=0 immediately, no tx_done.
- Parity (UART_TX_PARITY_EN defined), tx_data=8'h07 -> parity bit 1; frame 220 clocks at baud=20; tx_done at clock 220.
